// File: rtl/dispatch_controller_pkg.sv
// rtl/dispatch_controller_pkg.sv - shared station encoding and sizing for the dispatch controller
package dispatch_controller_pkg;

    typedef enum logic [1:0] {
        ST_ALU    = 2'b00,
        ST_LSU    = 2'b01,
        ST_BRANCH = 2'b10,
        ST_UPPER  = 2'b11
    } station_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    localparam int RS_DEPTH  = 4;
    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = $clog2(ROB_DEPTH);

endpackage

// File: rtl/dispatch_controller_credit.sv
// rtl/dispatch_controller_credit.sv - saturating per-station free-entry counter with flush reload
module station_credit #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic take,
    input  logic give,
    output logic avail
);

    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [CW-1:0] credit;
    logic [CW:0]   sum;

    // take is only ever asserted while avail is high, so sum cannot underflow
    always_comb begin
        sum = {1'b0, credit} + {{CW{1'b0}}, give} - {{CW{1'b0}}, take};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit <= FULL[CW-1:0];
        end else if (flush) begin
            credit <= FULL[CW-1:0];
        end else if (sum > FULL) begin
            credit <= FULL[CW-1:0];
        end else begin
            credit <= sum[CW-1:0];
        end
    end

    assign avail = (credit != '0);

endmodule

// File: rtl/dispatch_controller.sv
// rtl/dispatch_controller.sv - single-entry dispatch stage gating on station credit and ROB space
module dispatch_controller #(
    parameter  int RS_DEPTH  = dispatch_controller_pkg::RS_DEPTH,
    parameter  int ROB_DEPTH = dispatch_controller_pkg::ROB_DEPTH,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    input  logic [1:0]       inStation,
    input  logic             inRegWrite,
    output logic             inReady,
    input  logic [3:0]       rsRelease,
    input  logic             robCommit,
    input  logic             flush,
    output logic [3:0]       dispValid,
    output logic [TAG_W-1:0] dispTag,
    output logic             dispRegWrite,
    output logic [TAG_W:0]   robCount
);

    import dispatch_controller_pkg::*;

    localparam logic [TAG_W:0] ROB_FULL = (TAG_W + 1)'(ROB_DEPTH);

    state_e           state;
    station_e         held_station;
    logic             held_reg_write;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   rob_count;
    logic [3:0]       avail;

    logic go;
    logic fire;
    logic accept;
    logic commit;

    // go depends only on registered state; same-cycle releases and commits cannot help it
    assign go     = (state == S_HOLD) && avail[held_station] && (rob_count < ROB_FULL);
    assign fire   = go && !flush;
    assign inReady = !flush && ((state == S_EMPTY) || go);
    assign accept = inValid && inReady;
    assign commit = robCommit && (rob_count != '0);

    assign dispValid    = fire ? (4'b0001 << held_station) : 4'b0000;
    assign dispTag      = tail;
    assign dispRegWrite = held_reg_write;
    assign robCount     = rob_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_EMPTY;
            held_station   <= ST_ALU;
            held_reg_write <= 1'b0;
            tail           <= '0;
            rob_count      <= '0;
        end else if (flush) begin
            state          <= S_EMPTY;
            tail           <= '0;
            rob_count      <= '0;
        end else begin
            if (accept) begin
                state          <= S_HOLD;
                held_station   <= station_e'(inStation);
                held_reg_write <= inRegWrite;
            end else if (fire) begin
                state <= S_EMPTY;
            end
            tail      <= tail + TAG_W'(fire);
            rob_count <= rob_count + (TAG_W + 1)'(fire) - (TAG_W + 1)'(commit);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_credit
        station_credit #(
            .DEPTH(RS_DEPTH)
        ) u_credit (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .take  (fire && (held_station == station_e'(i))),
            .give  (rsRelease[i]),
            .avail (avail[i])
        );
    end

endmodule

// File: tb/tb_dispatch_controller.sv
// tb/tb_dispatch_controller.sv - directed self-checking bench for dispatch_controller
module tb_dispatch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic [1:0] inStation;
    logic       inRegWrite;
    logic       inReady;
    logic [3:0] rsRelease;
    logic       robCommit;
    logic       flush;
    logic [3:0] dispValid;
    logic [2:0] dispTag;
    logic       dispRegWrite;
    logic [3:0] robCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dispatch_controller dut (
        .clk          (clk),
        .reset        (reset),
        .inValid      (inValid),
        .inStation    (inStation),
        .inRegWrite   (inRegWrite),
        .inReady      (inReady),
        .rsRelease    (rsRelease),
        .robCommit    (robCommit),
        .flush        (flush),
        .dispValid    (dispValid),
        .dispTag      (dispTag),
        .dispRegWrite (dispRegWrite),
        .robCount     (robCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic rw,
                         input logic [3:0] rel, input logic com, input logic fl);
        inValid    = v;
        inStation  = st;
        inRegWrite = rw;
        rsRelease  = rel;
        robCommit  = com;
        flush      = fl;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // five back-to-back ALU instructions from a fresh state: four dispatch, fifth held
    task automatic alu_burst(input string tag);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0);
            mid();
            chk({tag, "_dv"}, dispValid, (k == 0) ? 4'b0000 : 4'b0001);
            if (k > 0) begin
                chk({tag, "_tag"}, dispTag, k - 1);
                chk({tag, "_rw"}, dispRegWrite, 1'b1);
            end
            chk({tag, "_rdy"}, inReady, 1'b1);
            tick();
        end
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk({tag, "_stall_dv"}, dispValid, 4'b0000);
        chk({tag, "_stall_rdy"}, inReady, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_dv", dispValid, 4'b0000);
        chk("rst_tag", dispTag, 3'd0);
        chk("rst_cnt", robCount, 4'd0);
        chk("rst_rw", dispRegWrite, 1'b0);
        reset = 1'b0;
        mid();
        chk("rst_rdy", inReady, 1'b1);
        tick();

        alu_burst("alu");
        tick();

        // release arrives while held: no dispatch this cycle, dispatch next with tag 4
        drive(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0, 1'b0);
        mid();
        chk("rel_same_dv", dispValid, 4'b0000);
        tick();
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk("rel_dv", dispValid, 4'b0001);
        chk("rel_tag", dispTag, 3'd4);
        tick();

        // ALU credit is back to zero: a new ALU instruction is held
        drive(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk("cr0_acc_rdy", inReady, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0, 1'b0);
        mid();
        chk("cr0_dv", dispValid, 4'b0000);
        chk("cr0_rdy", inReady, 1'b0);
        chk("cr0_cnt", robCount, 4'd5);
        tick();

        // flush while HOLD with go possible: everything discarded
        drive(1'b1, 2'b01, 1'b1, 4'b0000, 1'b1, 1'b1);
        mid();
        chk("fl_dv", dispValid, 4'b0000);
        chk("fl_rdy", inReady, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk("fl_cnt", robCount, 4'd0);
        chk("fl_tag", dispTag, 3'd0);
        chk("fl_rdy_after", inReady, 1'b1);
        chk("fl_dv_after", dispValid, 4'b0000);
        tick();

        // nine instructions across stations, ninth stalls on a full ROB
        for (int k = 0; k < 9; k++) begin
            logic [31:0] kk;
            kk = k;
            drive(1'b1, kk[1:0], kk[0], 4'b0000, 1'b0, 1'b0);
            mid();
            if (k > 0) begin
                chk("rob_dv", dispValid, 4'b0001 << ((k - 1) % 4));
                chk("rob_tag", dispTag, k - 1);
                chk("rob_rw", dispRegWrite, (k - 1) % 2);
            end
            chk("rob_rdy", inReady, 1'b1);
            tick();
        end
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0);
        mid();
        chk("full_dv", dispValid, 4'b0000);
        chk("full_rdy", inReady, 1'b0);
        chk("full_cnt", robCount, 4'd8);
        tick();
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk("wrap_dv", dispValid, 4'b0001);
        chk("wrap_tag", dispTag, 3'd0);
        chk("wrap_cnt", robCount, 4'd7);
        tick();

        // branch credit is 2; release coincident with a branch dispatch leaves it at 2
        drive(1'b1, 2'b10, 1'b1, 4'b0000, 1'b1, 1'b0);
        mid();
        chk("br_acc_cnt", robCount, 4'd8);
        tick();
        drive(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, 1'b0);
        mid();
        chk("br0_dv", dispValid, 4'b0100);
        chk("br0_tag", dispTag, 3'd1);
        chk("br0_cnt", robCount, 4'd7);
        tick();
        drive(1'b1, 2'b10, 1'b1, 4'b0000, 1'b1, 1'b0);
        mid();
        chk("br1_dv", dispValid, 4'b0100);
        chk("br1_tag", dispTag, 3'd2);
        tick();
        mid();
        chk("br2_dv", dispValid, 4'b0100);
        chk("br2_tag", dispTag, 3'd3);
        tick();
        drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        mid();
        chk("br3_dv", dispValid, 4'b0000);
        chk("br3_rdy", inReady, 1'b0);
        chk("br3_cnt", robCount, 4'd7);

        // asynchronous reset pulse mid-HOLD, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("arst_dv", dispValid, 4'b0000);
        chk("arst_tag", dispTag, 3'd0);
        chk("arst_cnt", robCount, 4'd0);
        chk("arst_rw", dispRegWrite, 1'b0);
        #1;
        reset = 1'b0;
        mid();
        chk("arst_rdy", inReady, 1'b1);
        chk("arst_dv_after", dispValid, 4'b0000);
        tick();

        // release at full credit is ignored: fifth ALU instruction still stalls
        drive(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0, 1'b0);
        mid();
        tick();
        alu_burst("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_controller.md
DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 Parameter: RS_DEPTH, default 4, entries per reservation station.
REQ-002 Parameter: ROB_DEPTH, default 8, power of two, reorder-buffer entries; TAG_W = log2(ROB_DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 inValid  input  1  decoded instruction present.
REQ-006 inStation  input  2  target station: 00 ALU, 01 load/store, 10 branch, 11 LUI/AUIPC.
REQ-007 inRegWrite  input  1  instruction writes a destination register.
REQ-008 inReady  output  1  controller accepts instruction this cycle.
REQ-009 rsRelease  input  4  one bit per station; that station freed one entry this cycle.
REQ-010 robCommit  input  1  ROB head retired this cycle.
REQ-011 flush  input  1  mispredict/exception recovery; discard all speculative state.
REQ-012 dispValid  output  4  one-hot; instruction written into that station this cycle.
REQ-013 dispTag  output  TAG_W  ROB tag allocated to the dispatched instruction.
REQ-014 dispRegWrite  output  1  registered inRegWrite of the dispatched instruction.
REQ-015 robCount  output  TAG_W+1  occupied ROB entries.

Function
REQ-016 States: EMPTY (no held instruction), HOLD (one instruction in dispatch register).
REQ-017 Accept = inValid && inReady; accepted station/regWrite captured into dispatch register; state -> HOLD.
REQ-018 go = HOLD && credit[station] > 0 && robCount < ROB_DEPTH; computed only from registered state.
REQ-019 dispValid[station] = go; all other dispValid bits 0; dispTag = tail pointer; dispRegWrite = held regWrite.
REQ-020 inReady = EMPTY || go (single-entry pipeline; accept and dispatch may occur in same cycle, leaving state HOLD with new instruction).
REQ-021 HOLD && !go && no flush: hold contents unchanged, inReady low.
REQ-022 HOLD && go && !Accept: state -> EMPTY.
REQ-023 Per-station credit: next = credit - (go && station==i) + rsRelease[i]; saturate at RS_DEPTH (release at full credit ignored); release never affects same-cycle go.
REQ-024 Tail pointer increments by 1 on go, wraps ROB_DEPTH-1 -> 0.
REQ-025 robCount next = robCount + go - (robCommit && robCount>0); commit at zero ignored.
REQ-026 flush has priority: dispValid forced 0 that cycle, input not accepted (inReady 0), next state EMPTY, tail 0, robCount 0, all credits RS_DEPTH; rsRelease/robCommit that cycle ignored.
REQ-027 Latency: instruction accepted in cycle N dispatches no earlier than N+1.

Reset
REQ-028 reset asserted (any time, including mid-HOLD): state EMPTY, tail 0, robCount 0, credits RS_DEPTH, dispValid 0, dispTag 0, dispRegWrite 0, inReady 1 after reset deasserts.

Structure
REQ-029 Shared package holds station enum (ALU, LSU, BRANCH, UPPER = 00..11), RS_DEPTH, ROB_DEPTH, TAG_W.
REQ-030 One sub-module, station_credit (up/down saturating counter with flush reload), instanced 4x.

Verification
REQ-031 Reset, then ALU instr each cycle for 5 cycles, no releases -> 4 dispatches tags 0..3 on dispValid=0001, 5th held, inReady 0.
REQ-032 From REQ-031 end, rsRelease=0001 one cycle -> 5th dispatches next cycle with tag 4, credit[0] back to 0.
REQ-033 8 dispatches across stations with ample credit, no commits -> robCount 8, 9th stalls; one robCommit -> dispatches tag 0 (wrap).
REQ-034 HOLD with go and branch same cycle: rsRelease[2]=1 and go on station 10 -> credit[2] unchanged.
REQ-035 flush while HOLD, robCount 5 -> dispValid 0 that cycle, next cycle EMPTY, robCount 0, tail 0, credits 4.
REQ-036 reset pulsed asynchronously mid-HOLD (not clock-aligned) -> all outputs zero immediately, inReady 1 after release.
